// File: rtl/gshare_predictor_mp_pkg.sv
// Shared types, default configuration and index hash for the gshare direction predictor.
package gshare_predictor_mp_pkg;

  localparam int GSH_PC_BITS      = 32;
  localparam int GSH_HISTORY_BITS = 2;
  localparam int GSH_SIZE         = 256;
  localparam int GSH_CNT_BITS     = 2;
  localparam int FETCH_LANES      = 2;
  localparam int GSH_PC_LSB       = 2;

  typedef struct packed {
    logic [GSH_PC_BITS-1:0] pc;
    logic                   valid;
  } gsh_lookup_s;

  typedef struct packed {
    logic [GSH_PC_BITS-1:0] pc;
    logic                   taken;
    logic                   mispredict;
    logic                   valid;
  } gsh_update_s;

  // Width-generic hash: pc[pc_lsb +: idx_bits] XOR zero-extended history.
  function automatic logic [31:0] gsh_index(input logic [63:0]   pc,
                                            input logic [31:0]   hist,
                                            input int unsigned   pc_lsb,
                                            input int unsigned   idx_bits);
    logic [63:0] mask;
    logic [63:0] hashed;
    mask   = (64'd1 << idx_bits) - 64'd1;
    hashed = ((pc >> pc_lsb) ^ {32'd0, hist}) & mask;
    return hashed[31:0];
  endfunction

endpackage

// File: rtl/gshare_predictor_mp_sat_counter_table.sv
// Saturating counter table: multi-port registered read of counter MSBs, one
// saturating write port. Reads see the value from before a same-cycle write.
module sat_counter_table #(
  parameter int TABLE_SIZE = 256,
  parameter int CNT_BITS   = 2,
  parameter int LANES      = 2,
  parameter int IDX_BITS   = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           rd_en_i,
  input  logic [LANES-1:0][IDX_BITS-1:0] rd_idx_i,
  output logic [LANES-1:0]               rd_msb_o,
  input  logic                           wr_en_i,
  input  logic [IDX_BITS-1:0]            wr_idx_i,
  input  logic                           wr_up_i
);

  localparam logic [CNT_BITS-1:0] WEAK = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);
  localparam logic [CNT_BITS-1:0] MAX  = {CNT_BITS{1'b1}};

  logic [CNT_BITS-1:0] cnt_q [TABLE_SIZE];
  logic [CNT_BITS-1:0] cnt_cur;
  logic [CNT_BITS-1:0] cnt_d;
  logic [LANES-1:0]    rd_msb_q;

  always_comb begin
    cnt_cur = cnt_q[wr_idx_i];
    cnt_d   = cnt_cur;
    if (wr_up_i && (cnt_cur != MAX)) begin
      cnt_d = cnt_cur + CNT_BITS'(1);
    end else if (!wr_up_i && (cnt_cur != '0)) begin
      cnt_d = cnt_cur - CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TABLE_SIZE; i++) begin
        cnt_q[i] <= WEAK;
      end
      rd_msb_q <= '0;
    end else begin
      if (wr_en_i) begin
        cnt_q[wr_idx_i] <= cnt_d;
      end
      if (rd_en_i) begin
        for (int l = 0; l < LANES; l++) begin
          rd_msb_q[l] <= cnt_q[rd_idx_i[l]][CNT_BITS-1];
        end
      end
    end
  end

  assign rd_msb_o = rd_msb_q;

endmodule

// File: rtl/gshare_predictor_mp.sv
// Parametrised gshare direction predictor with speculative global history that
// is recovered from the retired history on mispredict or flush.
module gshare_predictor_mp
  import gshare_predictor_mp_pkg::*;
#(
  parameter int PC_BITS      = GSH_PC_BITS,
  parameter int FETCH_LANES  = gshare_predictor_mp_pkg::FETCH_LANES,
  parameter int HISTORY_BITS = GSH_HISTORY_BITS,
  parameter int TABLE_SIZE   = GSH_SIZE,
  parameter int CNT_BITS     = GSH_CNT_BITS,
  parameter int PC_LSB       = GSH_PC_LSB
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rd_valid_i,
  input  logic [PC_BITS-1:0]     rd_pc_i,
  output logic                   pred_valid_o,
  output logic [FETCH_LANES-1:0] pred_taken_o,
  input  logic                   spec_valid_i,
  input  logic                   spec_taken_i,
  input  logic                   upd_valid_i,
  input  logic [PC_BITS-1:0]     upd_pc_i,
  input  logic                   upd_taken_i,
  input  logic                   upd_mispredict_i,
  input  logic                   flush_i
);

  localparam int IDX_BITS = $clog2(TABLE_SIZE);

  gsh_lookup_s lk;
  gsh_update_s up;

  logic [HISTORY_BITS-1:0] spec_hist_q, spec_hist_d, spec_shift;
  logic [HISTORY_BITS-1:0] ret_hist_q, ret_hist_d, ret_shift;
  logic                    pred_valid_q;

  logic [FETCH_LANES-1:0][IDX_BITS-1:0] rd_idx;
  logic [IDX_BITS-1:0]                  wr_idx;

  always_comb begin
    lk.pc         = GSH_PC_BITS'(rd_pc_i);
    lk.valid      = rd_valid_i;
    up.pc         = GSH_PC_BITS'(upd_pc_i);
    up.taken      = upd_taken_i;
    up.mispredict = upd_mispredict_i;
    up.valid      = upd_valid_i;
  end

  generate
    if (HISTORY_BITS == 1) begin : g_hist1
      assign ret_shift  = up.taken;
      assign spec_shift = spec_taken_i;
    end else begin : g_histn
      assign ret_shift  = {ret_hist_q[HISTORY_BITS-2:0], up.taken};
      assign spec_shift = {spec_hist_q[HISTORY_BITS-2:0], spec_taken_i};
    end
  endgenerate

  // ret_hist_d already folds in a same-cycle update, so flush recovery and
  // mispredict recovery both restore from it; any spec shift that cycle is lost.
  always_comb begin
    ret_hist_d  = up.valid ? ret_shift : ret_hist_q;
    spec_hist_d = spec_hist_q;
    if (up.valid && up.mispredict) begin
      spec_hist_d = ret_hist_d;
    end else if (flush_i) begin
      spec_hist_d = ret_hist_d;
    end else if (spec_valid_i) begin
      spec_hist_d = spec_shift;
    end
  end

  always_comb begin
    for (int l = 0; l < FETCH_LANES; l++) begin
      rd_idx[l] = IDX_BITS'(gsh_index(64'(lk.pc + GSH_PC_BITS'(4 * l)),
                                      32'(spec_hist_q), PC_LSB, IDX_BITS));
    end
    wr_idx = IDX_BITS'(gsh_index(64'(up.pc), 32'(ret_hist_q), PC_LSB, IDX_BITS));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spec_hist_q  <= '0;
      ret_hist_q   <= '0;
      pred_valid_q <= 1'b0;
    end else begin
      spec_hist_q  <= spec_hist_d;
      ret_hist_q   <= ret_hist_d;
      pred_valid_q <= lk.valid;
    end
  end

  sat_counter_table #(
    .TABLE_SIZE (TABLE_SIZE),
    .CNT_BITS   (CNT_BITS),
    .LANES      (FETCH_LANES),
    .IDX_BITS   (IDX_BITS)
  ) u_table (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_en_i  (lk.valid),
    .rd_idx_i (rd_idx),
    .rd_msb_o (pred_taken_o),
    .wr_en_i  (up.valid),
    .wr_idx_i (wr_idx),
    .wr_up_i  (up.taken)
  );

  assign pred_valid_o = pred_valid_q;

endmodule

// File: tb/tb_gshare_predictor_mp.sv
// Directed and random checks of gshare_predictor_mp against a reference model
// with a prediction scoreboard.
module tb_gshare_predictor_mp;

  logic        clk;
  logic        rst_n;
  logic        rd_valid_i;
  logic [31:0] rd_pc_i;
  logic        pred_valid_o;
  logic [1:0]  pred_taken_o;
  logic        spec_valid_i;
  logic        spec_taken_i;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic        upd_taken_i;
  logic        upd_mispredict_i;
  logic        flush_i;

  gshare_predictor_mp dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .rd_valid_i       (rd_valid_i),
    .rd_pc_i          (rd_pc_i),
    .pred_valid_o     (pred_valid_o),
    .pred_taken_o     (pred_taken_o),
    .spec_valid_i     (spec_valid_i),
    .spec_taken_i     (spec_taken_i),
    .upd_valid_i      (upd_valid_i),
    .upd_pc_i         (upd_pc_i),
    .upd_taken_i      (upd_taken_i),
    .upd_mispredict_i (upd_mispredict_i),
    .flush_i          (flush_i)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model and scoreboard
  int         cnt_m [256];
  logic [1:0] spec_m;
  logic [1:0] ret_m;
  logic [1:0] last_pred;
  logic [1:0] exp_q [$];
  int         n_cmp;
  int         n_err;

  function automatic int idx_m(input logic [31:0] pc, input logic [1:0] h);
    logic [7:0] a;
    a = pc[9:2];
    return int'(a ^ {6'd0, h});
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) cnt_m[i] = 1;
    spec_m    = 2'b00;
    ret_m     = 2'b00;
    last_pred = 2'b00;
    exp_q.delete();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    rd_valid_i       = 1'b0;
    spec_valid_i     = 1'b0;
    spec_taken_i     = 1'b0;
    upd_valid_i      = 1'b0;
    upd_taken_i      = 1'b0;
    upd_mispredict_i = 1'b0;
    flush_i          = 1'b0;
  endtask

  // Drives the currently set inputs through one clock edge and checks outputs.
  task automatic cycle(input string tag);
    logic [1:0] exp_pred;
    logic [1:0] rn;
    logic [1:0] sn;
    logic       exp_pv;
    int         ix;
    for (int l = 0; l < 2; l++) begin
      ix = idx_m(rd_pc_i + 32'(4 * l), spec_m);
      exp_pred[l] = (cnt_m[ix] >= 2);
    end
    if (rd_valid_i) exp_q.push_back(exp_pred);
    exp_pv = rd_valid_i;
    rn = ret_m;
    if (upd_valid_i) begin
      ix = idx_m(upd_pc_i, ret_m);
      if (upd_taken_i && cnt_m[ix] < 3) cnt_m[ix] = cnt_m[ix] + 1;
      else if (!upd_taken_i && cnt_m[ix] > 0) cnt_m[ix] = cnt_m[ix] - 1;
      rn = {ret_m[0], upd_taken_i};
    end
    if (upd_valid_i && upd_mispredict_i) sn = rn;
    else if (flush_i) sn = rn;
    else if (spec_valid_i) sn = {spec_m[0], spec_taken_i};
    else sn = spec_m;
    ret_m  = rn;
    spec_m = sn;
    @(posedge clk);
    #1;
    check({tag, ".pv"}, 32'(pred_valid_o), 32'(exp_pv));
    if (exp_pv) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL %s.sb: observed empty queue expected an entry", tag);
      end else begin
        last_pred = exp_q.pop_front();
        check({tag, ".pred"}, 32'(pred_taken_o), 32'(last_pred));
      end
    end else begin
      check({tag, ".hold"}, 32'(pred_taken_o), 32'(last_pred));
    end
    clear_inputs();
  endtask

  task automatic do_rd(input logic [31:0] pc, input string tag);
    rd_valid_i = 1'b1;
    rd_pc_i    = pc;
    cycle(tag);
  endtask

  task automatic do_upd(input logic [31:0] pc, input logic t, input logic m, input string tag);
    upd_valid_i      = 1'b1;
    upd_pc_i         = pc;
    upd_taken_i      = t;
    upd_mispredict_i = m;
    cycle(tag);
  endtask

  task automatic check_hist(input string tag);
    check({tag, ".spec"}, 32'(dut.spec_hist_q), 32'(spec_m));
    check({tag, ".ret"}, 32'(dut.ret_hist_q), 32'(ret_m));
  endtask

  task automatic check_cnt(input int ix, input string tag);
    check(tag, 32'(dut.u_table.cnt_q[ix]), 32'(cnt_m[ix]));
  endtask

  // Two not-taken updates flush retired history back to zero.
  task automatic zero_ret();
    do_upd(32'h200, 1'b0, 1'b0, "zr0");
    do_upd(32'h200, 1'b0, 1'b0, "zr1");
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rd_pc_i  = '0;
    upd_pc_i = '0;
    clear_inputs();
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.pv", 32'(pred_valid_o), 32'd0);
    check("rst.pred", 32'(pred_taken_o), 32'd0);
    check_hist("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // 1: first lookup after reset is weakly not-taken on both lanes
    do_rd(32'h100, "t1");

    // 2: taken updates saturate at 3
    do_upd(32'h100, 1'b1, 1'b0, "t2a");
    check_cnt(32'h40, "t2.cnt2");
    zero_ret();
    do_upd(32'h100, 1'b1, 1'b0, "t2b");
    check_cnt(32'h40, "t2.cnt3");
    zero_ret();
    do_upd(32'h100, 1'b1, 1'b0, "t2c");
    check_cnt(32'h40, "t2.sat3");
    zero_ret();
    do_rd(32'h100, "t2.rd");

    // 3: not-taken updates floor at 0
    for (int i = 0; i < 4; i++) begin
      do_upd(32'h300, 1'b0, 1'b0, "t3");
      check_cnt(32'hC0, "t3.cnt");
    end
    do_rd(32'h300, "t3.rd");

    // 4: spec shifts, then mispredict recovery drops a same-cycle spec shift
    for (int i = 0; i < 3; i++) begin
      spec_valid_i = 1'b1;
      spec_taken_i = 1'b1;
      cycle("t4.spec");
    end
    check_hist("t4.pre");
    spec_valid_i = 1'b1;
    spec_taken_i = 1'b1;
    upd_valid_i      = 1'b1;
    upd_pc_i         = 32'h300;
    upd_taken_i      = 1'b0;
    upd_mispredict_i = 1'b1;
    cycle("t4.rec");
    check_hist("t4.post");

    // flush recovery, flush with update, and mispredict without valid
    spec_valid_i = 1'b1; spec_taken_i = 1'b1; cycle("fl.s0");
    spec_valid_i = 1'b1; spec_taken_i = 1'b1; cycle("fl.s1");
    flush_i = 1'b1; cycle("fl.f");
    check_hist("fl.f");
    spec_valid_i = 1'b1; spec_taken_i = 1'b0;
    flush_i = 1'b1;
    upd_valid_i = 1'b1; upd_pc_i = 32'h104; upd_taken_i = 1'b1;
    cycle("fl.fu");
    check_hist("fl.fu");
    spec_valid_i = 1'b1; spec_taken_i = 1'b1;
    upd_mispredict_i = 1'b1;
    cycle("fl.mnv");
    check_hist("fl.mnv");

    // 5: same-cycle read and write of index 0x40 returns the old value
    zero_ret();
    flush_i = 1'b1; cycle("t5.fl");
    do_upd(32'h100, 1'b0, 1'b0, "t5.d0");
    do_upd(32'h100, 1'b0, 1'b0, "t5.d1");
    check_cnt(32'h40, "t5.cnt1");
    rd_valid_i = 1'b1; rd_pc_i = 32'h100;
    upd_valid_i = 1'b1; upd_pc_i = 32'h100; upd_taken_i = 1'b1;
    cycle("t5.rbw");
    do_rd(32'h100, "t5.after");

    // random mixed traffic
    for (int i = 0; i < 300; i++) begin
      logic [31:0] pcs [4];
      pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h200; pcs[3] = 32'h3FC;
      rd_valid_i       = ($urandom_range(0, 1) == 1);
      rd_pc_i          = ($urandom_range(0, 3) == 0) ? ($urandom() & 32'hFFFF_FFFC)
                                                     : pcs[$urandom_range(0, 3)];
      spec_valid_i     = ($urandom_range(0, 2) == 0);
      spec_taken_i     = ($urandom_range(0, 1) == 1);
      upd_valid_i      = ($urandom_range(0, 1) == 1);
      upd_pc_i         = pcs[$urandom_range(0, 3)];
      upd_taken_i      = ($urandom_range(0, 3) != 0);
      upd_mispredict_i = ($urandom_range(0, 5) == 0);
      flush_i          = ($urandom_range(0, 15) == 0);
      cycle("rnd");
      if (i % 50 == 0) check_hist("rnd");
    end

    // 6: async reset mid-stream with spec history 11 and a valid prediction out
    flush_i = 1'b1; cycle("t6.fl");
    spec_valid_i = 1'b1; spec_taken_i = 1'b1; cycle("t6.s0");
    spec_valid_i = 1'b1; spec_taken_i = 1'b1; cycle("t6.s1");
    do_rd(32'h100, "t6.rd");
    check("t6.spec11", 32'(dut.spec_hist_q), 32'h3);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6.async.pv", 32'(pred_valid_o), 32'd0);
    check("t6.async.pred", 32'(pred_taken_o), 32'd0);
    model_reset();
    check_hist("t6.async");
    @(negedge clk);
    rst_n = 1'b1;
    do_rd(32'h100, "t6.post0");
    do_rd(32'h300, "t6.post1");
    check_cnt(32'h40, "t6.cnt");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gshare_predictor_mp.md
Name: gshare_predictor_mp

Overview:
- Parametrised next-generation gshare direction predictor for the IF stage.
- Generalises the fixed 2-bit-history / 2-bit-counter / 256-entry gshare to configurable history length, counter width, table size and fetch-lane count.
- Adds speculative global history with recovery from the retired history on mispredict or flush.
- Sits beside the BTB/RAS: fetch reads one prediction per lane; the commit side updates counters and history.

Parameters:
- PC_BITS, 32, PC width.
- FETCH_LANES, 2, instructions predicted per fetch packet. Lane i PC = rd_pc_i + 4*i.
- HISTORY_BITS, 2, global history length, 1..IDX_BITS.
- TABLE_SIZE, 256, number of counters, power of two. IDX_BITS = clog2(TABLE_SIZE).
- CNT_BITS, 2, saturating counter width, 1..4.
- PC_LSB, 2, lowest PC bit used in the index.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- rd_valid_i  in  1  fetch lookup request
- rd_pc_i  in  PC_BITS  fetch packet base PC
- pred_valid_o  out  1  predictions valid, 1 cycle after rd_valid_i
- pred_taken_o  out  FETCH_LANES  per-lane taken prediction
- spec_valid_i  in  1  fetch committed to a predicted branch; shift speculative history
- spec_taken_i  in  1  direction shifted into speculative history
- upd_valid_i  in  1  resolved conditional branch update
- upd_pc_i  in  PC_BITS  resolved branch PC
- upd_taken_i  in  1  actual outcome
- upd_mispredict_i  in  1  prediction was wrong; recover speculative history
- flush_i  in  1  pipeline flush; recover speculative history

Behaviour:
- Reset (async, rst_n=0):
  - all counters = 2^(CNT_BITS-1)-1 (weakly not-taken);
  - spec_hist = 0, ret_hist = 0;
  - pred_valid_o = 0, pred_taken_o = 0.
- Index: idx(pc, h) = pc[PC_LSB +: IDX_BITS] XOR zero-extended h.
  - Lookup uses spec_hist.
  - Update uses ret_hist, sampled before its own shift.
- Read:
  - Registered, latency 1.
  - pred_taken_o[i] = MSB of counter[idx(rd_pc_i + 4*i, spec_hist)], sampled at the rd_valid_i edge.
  - pred_valid_o = rd_valid_i delayed one cycle.
  - When rd_valid_i = 0, pred_taken_o holds its last value.
- Counter update on upd_valid_i:
  - counter[idx(upd_pc_i, ret_hist)] saturating +1 if taken, else -1.
  - No wrap at 0 or 2^CNT_BITS-1.
- Same-cycle read and write to the same index: read returns the pre-update value (read-before-write).
- Two lanes mapping to the same index read the same counter. Legal, no conflict.
- ret_hist: on upd_valid_i, ret_hist <= {ret_hist[HISTORY_BITS-2:0], upd_taken_i}. For HISTORY_BITS = 1: ret_hist <= upd_taken_i.
- spec_hist, next value by priority:
  1. upd_valid_i & upd_mispredict_i → the new ret_hist value (including upd_taken_i).
  2. flush_i → the new ret_hist value if upd_valid_i, else current ret_hist.
  3. spec_valid_i → shift in spec_taken_i.
  4. otherwise hold.
- Simultaneous spec_valid_i with recovery (priority 1 or 2): the spec shift is dropped.
- upd_mispredict_i without upd_valid_i: ignored.
- Reset mid-operation: all state returns to reset values immediately. No pending state survives.

Decomposition:
- Shared package:
  - gsh_lookup_s {pc, valid};
  - gsh_update_s {pc, taken, mispredict, valid};
  - constants GSH_HISTORY_BITS, GSH_SIZE, GSH_CNT_BITS, FETCH_LANES;
  - function gsh_index(pc, hist).
- Sub-module sat_counter_table:
  - TABLE_SIZE x CNT_BITS;
  - FETCH_LANES read ports, 1 write port;
  - async reset to the weak value;
  - saturating increment/decrement.

Test Plan:
1. Reset, then rd_valid_i=1, rd_pc_i=0x100, lanes=2 → next cycle pred_valid_o=1, pred_taken_o=2'b00.
2. upd_valid_i with upd_pc_i=0x100, upd_taken_i=1, twice, hist=0 at both updates (drive spec/ret history back via mispredict/flush as needed) → counter[0x40] goes 1→2→3. A third taken update leaves it at 3. Lookup of 0x100 at spec_hist=0 returns taken.
3. Starting from counter 0, apply three not-taken updates to the same index → counter stays 0, no wrap to 3.
4. spec_valid_i=1, spec_taken_i=1 three times (ret_hist=0), then upd_valid_i=1 with upd_mispredict_i=1 and upd_taken_i=0 in the same cycle as spec_valid_i=1 → next cycle spec_hist=2'b00 and ret_hist=2'b00. The spec shift is dropped.
5. Same-cycle read and update of index 0x40 with counter=1 and upd_taken_i=1 → pred_taken_o[0]=0 (old value). The following read returns 1.
6. Assert rst_n=0 asynchronously mid-stream with spec_hist=2'b11 and pred_valid_o=1 → outputs go to 0 without a clock edge. Post-reset lookups return weakly-not-taken.
